// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: captures a/b on start, walks one
// bit pair per cycle LSB first, and publishes a one-hot l/e/g result with a done pulse.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  // One extra counter bit so the count to WIDTH-1 can never wrap early.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t           r_state;
  rel_t             r_rel;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  rel_t             w_rel_next;
  logic             w_last_bit;

  // Later (more significant) differing bits overwrite earlier decisions.
  always_comb begin
    w_rel_next = r_rel;
    if (r_a[0] && !r_b[0]) begin
      w_rel_next = REL_GT;
    end else if (!r_a[0] && r_b[0]) begin
      w_rel_next = REL_LT;
    end
  end

  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rel   <= REL_EQ;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      l       <= 1'b0;
      e       <= 1'b0;
      g       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_rel   <= REL_EQ;
            r_state <= RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          r_rel <= w_rel_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_bit) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            l       <= (w_rel_next == REL_LT);
            e       <= (w_rel_next == REL_EQ);
            g       <= (w_rel_next == REL_GT);
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: WIDTH=8 directed scenarios plus
// an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy, done, l, e, g;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4, done4, l4, e4, g4;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp4_q[$];

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .l(l), .e(e), .g(g)
  );

  serial_mag_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .l(l4), .e(e4), .g(g4)
  );

  // Reference relation as {l,e,g}.
  function automatic logic [2:0] ref_leg(input int unsigned x, input int unsigned y);
    if (x < y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Drive start for the edge following this negedge and queue the expected result.
  task automatic issue8(input logic [7:0] xa, input logic [7:0] xb);
    start = 1'b1;
    a     = xa;
    b     = xb;
    exp_q.push_back(ref_leg(xa, xb));
  endtask

  // Follow a run until done; edges counts posedges after the one that sampled start.
  task automatic run8(input int inj_at, input logic [7:0] ia, input logic [7:0] ib,
                      output int edges, output int busy_n);
    int n;
    n      = 0;
    busy_n = 0;
    edges  = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) begin
        edges = n - 1;
        break;
      end
      if (n == 1) begin
        start = 1'b0;
        a     = 8'hC3;
        b     = 8'h3C;
      end
      if (inj_at != 0 && n == inj_at) begin
        start = 1'b1;
        a     = ia;
        b     = ib;
      end
      if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
    end
  endtask

  task automatic check_result8(input string name);
    logic [2:0] exp;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: scoreboard empty when done observed", name);
    end else begin
      exp = exp_q.pop_front();
      compared++;
      if ({l, e, g} !== exp) begin
        mismatched++;
        $display("FAIL %s: leg=%b expected %b", name, {l, e, g}, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    start  = 1'b1;
    a      = 8'hFF;
    b      = 8'h00;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, l, e, g} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: busy,done,l,e,g=%b expected 00000", {busy, done, l, e, g});
    end
    compared++;
    if ({busy4, done4, l4, e4, g4} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs4: busy,done,l,e,g=%b expected 00000", {busy4, done4, l4, e4, g4});
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, done, l, e, g} !== 5'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: busy,done,l,e,g=%b expected 00000", {busy, done, l, e, g});
    end
    $display("test_reset: outputs cleared and held after release");
  endtask

  task automatic test_equal;
    int edges, busy_n;
    issue8(8'h5A, 8'h5A);
    run8(0, 8'h00, 8'h00, edges, busy_n);
    compared++;
    if (edges !== 8) begin
      mismatched++;
      $display("FAIL equal_latency: edges=%0d expected 8", edges);
    end
    compared++;
    if (busy_n !== 8) begin
      mismatched++;
      $display("FAIL equal_busy_cycles: busy=%0d expected 8", busy_n);
    end
    check_result8("equal_result");
    @(negedge clk);
    compared++;
    if ({busy, done, l, e, g} !== 5'b00010) begin
      mismatched++;
      $display("FAIL equal_pulse_hold: busy,done,l,e,g=%b expected 00010", {busy, done, l, e, g});
    end
    $display("test_equal: a=5a b=5a edges=%0d busy=%0d leg=%b", edges, busy_n, {l, e, g});
  endtask

  task automatic test_msb;
    int edges, busy_n;
    issue8(8'h80, 8'h7F);
    run8(0, 8'h00, 8'h00, edges, busy_n);
    compared++;
    if (edges !== 8) begin
      mismatched++;
      $display("FAIL msb_latency: edges=%0d expected 8", edges);
    end
    check_result8("msb_result");
    $display("test_msb: a=80 b=7f leg=%b", {l, e, g});
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int edges, busy_n;
    issue8(8'h01, 8'h02);
    run8(0, 8'h00, 8'h00, edges, busy_n);
    check_result8("b2b_first_result");
    issue8(8'hFF, 8'h00);
    run8(0, 8'h00, 8'h00, edges, busy_n);
    compared++;
    if (edges !== 8) begin
      mismatched++;
      $display("FAIL b2b_second_latency: edges=%0d expected 8", edges);
    end
    compared++;
    if (busy_n !== 8) begin
      mismatched++;
      $display("FAIL b2b_busy_cycles: busy=%0d expected 8", busy_n);
    end
    check_result8("b2b_second_result");
    $display("test_back_to_back: second edges=%0d leg=%b", edges, {l, e, g});
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int edges, busy_n;
    issue8(8'h10, 8'h20);
    run8(3, 8'hFF, 8'h00, edges, busy_n);
    compared++;
    if (edges !== 8) begin
      mismatched++;
      $display("FAIL busy_start_latency: edges=%0d expected 8", edges);
    end
    check_result8("busy_start_result");
    $display("test_start_busy: leg=%b edges=%0d", {l, e, g}, edges);
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int edges, busy_n, pulses;
    issue8(8'hAA, 8'h55);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({busy, done, l, e, g} !== 5'b0) begin
      mismatched++;
      $display("FAIL midrun_reset_outputs: busy,done,l,e,g=%b expected 00000", {busy, done, l, e, g});
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL midrun_no_done: active cycles=%0d expected 0", pulses);
    end
    compared++;
    if ({l, e, g} !== 3'b000) begin
      mismatched++;
      $display("FAIL midrun_leg_cleared: leg=%b expected 000", {l, e, g});
    end
    issue8(8'h33, 8'h34);
    run8(0, 8'h00, 8'h00, edges, busy_n);
    compared++;
    if (edges !== 8) begin
      mismatched++;
      $display("FAIL after_reset_latency: edges=%0d expected 8", edges);
    end
    check_result8("after_reset_result");
    $display("test_reset_midrun: restart leg=%b edges=%0d", {l, e, g}, edges);
    @(negedge clk);
  endtask

  task automatic test_exhaustive4;
    int n, bad_before;
    logic [2:0] exp;
    bad_before = mismatched;
    for (int i = 0; i < 256; i++) begin
      start4 = 1'b1;
      a4     = 4'(i >> 4);
      b4     = 4'(i);
      exp4_q.push_back(ref_leg(4'(i >> 4), 4'(i)));
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (done4) break;
        if (n == 1) start4 = 1'b0;
      end
      exp = exp4_q.pop_front();
      compared++;
      if (!done4 || n !== 5) begin
        mismatched++;
        $display("FAIL exh4_latency a=%h b=%h: negedges=%0d done=%b expected 5 and 1", a4, b4, n, done4);
      end
      compared++;
      if ({l4, e4, g4} !== exp) begin
        mismatched++;
        $display("FAIL exh4_result a=%h b=%h: leg=%b expected %b", 4'(i >> 4), 4'(i), {l4, e4, g4}, exp);
      end
    end
    start4 = 1'b0;
    @(negedge clk);
    $display("test_exhaustive4: 256 pairs, %0d new mismatches", mismatched - bad_before);
  endtask

  initial begin
    test_reset;
    test_equal;
    test_msb;
    test_back_to_back;
    test_start_busy;
    test_reset_midrun;
    test_exhaustive4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is WIDTH >= 2.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to capture a and b and begin a comparison.
REQ-006 SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-008 SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that a new result is available.
REQ-010 SHALL have port l, output, 1 bit: high when the last result is a < b.
REQ-011 SHALL have port e, output, 1 bit: high when the last result is a == b.
REQ-012 SHALL have port g, output, 1 bit: high when the last result is a > b.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-014 SHALL, in IDLE or DONE with start=1 at a rising edge, capture a and b into internal shift registers, clear the bit counter, set the running relation to EQ, and enter RUN.
REQ-015 SHALL ignore start while in RUN; captured operands and progress SHALL be unaffected.
REQ-016 SHALL examine one bit pair per RUN cycle, LSB first, and then shift both registers right by one.
REQ-017 SHALL update the running relation on each examined bit pair: a_bit=1, b_bit=0 -> GT; a_bit=0, b_bit=1 -> LT; equal bits -> relation unchanged.
- This gives "most significant differing bit decides" in LSB-first order.
REQ-018 SHALL leave RUN for DONE at the edge that processes bit WIDTH-1, i.e. exactly WIDTH edges after the edge that sampled start.
REQ-019 SHALL, at that same edge, load l/e/g from the final relation as one-hot (LT -> l, EQ -> e, GT -> g).
REQ-020 SHALL assert done for exactly the one cycle spent in DONE; with no start, DONE SHALL return to IDLE at the next edge.
REQ-021 SHALL, when start=1 during DONE, begin a new comparison immediately (DONE -> RUN) with no idle cycle.
REQ-022 SHALL drive busy high exactly when the state is RUN.
REQ-023 SHALL hold l/e/g stable from one done pulse until the next; intermediate relations SHALL never be visible on l/e/g.
REQ-024 SHALL size the bit counter as ceil(log2(WIDTH))+1 bits, so it cannot wrap before WIDTH bits are processed.
REQ-025 SHALL use registered outputs only, with no combinational path from a, b or start to any output.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-RUN, immediately force state=IDLE, busy=0, done=0, l=0, e=0, g=0, counter=0, and clear the shift registers.
REQ-027 SHALL, after rst deasserts, keep l=e=g=0 until the first done pulse; afterwards exactly one of l/e/g SHALL be high.
REQ-028 SHALL ignore start while rst=1.

Verification (WIDTH=8)
REQ-029 Equal operands: start with a=0x5A, b=0x5A -> busy high for 8 cycles, done pulses once on the 8th edge after start, then e=1, l=0, g=0.
REQ-030 MSB dominates: a=0x80, b=0x7F -> g=1, l=0, e=0, even though every lower bit has a < b.
REQ-031 Low-order difference: a=0x01, b=0x02 -> l=1; follow with a=0xFF, b=0x00 started in the DONE cycle -> second done pulse exactly 8 edges later with g=1, no idle gap.
REQ-032 Start while busy: start a=0x10, b=0x20; pulse start with a=0xFF, b=0x00 at cycle 3 -> ignored, result l=1 after 8 cycles.
REQ-033 Reset mid-run: rst at cycle 4 of RUN -> busy=0, done=0, l=e=g=0 immediately; no done pulse follows; a new start after reset completes normally.
REQ-034 Exhaustive: WIDTH=4, all 256 (a,b) pairs -> l/e/g match unsigned compare, exactly one high per result.
